mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter_rr_select.sv | 29 ++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the N-channel memory port arbiter.
// States, operation kinds and index-width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Combinational N-way picker: first set request at or after start,
// wrapping modulo N.
module rr_select
  import mem_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0] rot;

  always_comb begin
    rot   = N'({req, req} >> start);
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        idx   = IW'((int'(start) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges N_CH requesters onto one downstream memory port,
// one transaction in flight, fixed-priority or round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 0,
  localparam int MBE_W  = DATA_W / 8,
  localparam int IW     = idx_width(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req_read,
  input  logic [N_CH-1:0]          req_write,
  input  logic [N_CH*MBE_W-1:0]    req_mbe,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*DATA_W-1:0]   req_wdata,
  output logic [N_CH-1:0]          req_resp,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [MBE_W-1:0]         mem_mbe,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_resp,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy,
  output logic [IW-1:0]            grant_id
);

  state_t            state_q;
  state_t            state_d;
  logic              grant_en;
  logic              resp_en;
  logic [N_CH-1:0]   act;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     start;
  logic [IW-1:0]     nxt_ptr;
  logic              sel_valid;
  logic [IW-1:0]     sel_idx;
  op_t               sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [MBE_W-1:0]  sel_mbe;

  assign act   = req_read | req_write;
  assign start = (RR_MODE != 0) ? rr_ptr : '0;

  rr_select #(
    .N  (N_CH),
    .IW (IW)
  ) u_sel (
    .req   (act),
    .start (start),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  // Write wins when a channel raises both read and write.
  always_comb begin
    sel_op    = OP_READ;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mbe   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_idx == IW'(i)) begin
        sel_op    = req_write[i] ? OP_WRITE : OP_READ;
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_mbe   = req_mbe[i*MBE_W +: MBE_W];
      end
    end
  end

  assign nxt_ptr = (sel_idx == IW'(N_CH - 1)) ? '0
                 : sel_idx + IW'(1);

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    resp_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          grant_en = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          resp_en = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_mbe   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_resp  <= '0;
      req_rdata <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
    end else begin
      req_resp <= '0;
      if (grant_en) begin
        mem_read  <= (sel_op == OP_READ);
        mem_write <= (sel_op == OP_WRITE);
        mem_mbe   <= sel_mbe;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        busy      <= 1'b1;
        grant_id  <= sel_idx;
        rr_ptr    <= nxt_ptr;
      end
      if (resp_en) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        req_rdata <= mem_rdata;
        for (int i = 0; i < N_CH; i++)
          req_resp[i] <= (grant_id == IW'(i));
      end
      if (state_q == DONE) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two 3-channel arbiters (fixed priority, round robin)
// driven by random requesters and a random-latency memory model.
module tb_mem_port_arbiter;

  localparam int N = 3;

  typedef struct {
    int          e;
    int          ch;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
    int          cyc;
  } mexp_t;

  typedef struct {
    int          e;
    int          ch;
    bit          rd;
    logic [31:0] rdata;
    int          cyc;
  } rexp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0]   req_read  [2];
  logic [N-1:0]   req_write [2];
  logic [N*4-1:0] req_mbe   [2];
  logic [N*32-1:0] req_addr [2];
  logic [N*32-1:0] req_wdata[2];
  logic [N-1:0]   req_resp  [2];
  logic [31:0]    req_rdata [2];
  logic           mem_read  [2];
  logic           mem_write [2];
  logic [3:0]     mem_mbe   [2];
  logic [31:0]    mem_addr  [2];
  logic [31:0]    mem_wdata [2];
  logic           mem_resp  [2];
  logic [31:0]    mem_rdata [2];
  logic           busy      [2];
  logic [1:0]     grant_id  [2];

  mem_port_arbiter #(
    .N_CH(N), .ADDR_W(32), .DATA_W(32), .RR_MODE(0)
  ) u_fp (
    .clk(clk), .rst(rst),
    .req_read(req_read[0]), .req_write(req_write[0]),
    .req_mbe(req_mbe[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_resp(req_resp[0]),
    .req_rdata(req_rdata[0]), .mem_read(mem_read[0]),
    .mem_write(mem_write[0]), .mem_mbe(mem_mbe[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_resp(mem_resp[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0]), .grant_id(grant_id[0])
  );

  mem_port_arbiter #(
    .N_CH(N), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)
  ) u_rr (
    .clk(clk), .rst(rst),
    .req_read(req_read[1]), .req_write(req_write[1]),
    .req_mbe(req_mbe[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_resp(req_resp[1]),
    .req_rdata(req_rdata[1]), .mem_read(mem_read[1]),
    .mem_write(mem_write[1]), .mem_mbe(mem_mbe[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_resp(mem_resp[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1]), .grant_id(grant_id[1])
  );

  int errs;
  int chks;

  mexp_t mq[$];
  rexp_t rq[$];

  bit served [2][N];
  int rel    [2][N];
  bit infl   [2];
  bit crd    [2];
  int tg     [2];
  int rcyc   [2];
  int cch    [2];
  int free_at[2];
  int ptr    [2];

  bit    zchk;
  bit    mon_en;
  bit    fin;
  bit    pact[2];
  int    bchk[2];
  mexp_t cur [2];

  // One cycle of requester, memory and reference-arbiter behaviour.
  task automatic drive(input int mode);
    for (int g = 0; g < 2; g++) begin
      mem_resp[g] = 1'b0;
      if (infl[g] && cyc == rcyc[g]) begin
        mem_rdata[g] = $urandom;
        mem_resp[g]  = 1'b1;
        rq.push_back('{e: g, ch: cch[g], rd: crd[g],
                       rdata: mem_rdata[g], cyc: cyc + 1});
        infl[g]    = 1'b0;
        free_at[g] = cyc + 2;
        rel[g][cch[g]] = cyc + 2;
      end else if (!(infl[g] && cyc > tg[g])
                   && $urandom_range(7) == 0) begin
        mem_rdata[g] = $urandom;
        mem_resp[g]  = 1'b1;
      end
      for (int ch = 0; ch < N; ch++) begin
        if (rel[g][ch] == cyc) begin
          req_read[g][ch]  = 1'b0;
          req_write[g][ch] = 1'b0;
          served[g][ch]    = 1'b0;
          rel[g][ch]       = -1;
        end
        if (!req_read[g][ch] && !req_write[g][ch]
            && (mode == 2
                || (mode == 1 && $urandom_range(3) == 0))) begin
          int kind;
          kind = $urandom_range(2);
          req_read[g][ch]  = (kind != 1);
          req_write[g][ch] = (kind != 0);
          req_addr[g][ch*32 +: 32]  = $urandom;
          req_wdata[g][ch*32 +: 32] = $urandom;
          req_mbe[g][ch*4 +: 4]     = 4'($urandom);
        end
      end
      if (!infl[g] && cyc >= free_at[g]) begin
        int w;
        w = -1;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (g == 1) ? (ptr[g] + k) % N : k;
          if (w < 0 && !served[g][j]
              && (req_read[g][j] || req_write[g][j]))
            w = j;
        end
        if (w >= 0) begin
          served[g][w] = 1'b1;
          infl[g] = 1'b1;
          tg[g]   = cyc;
          rcyc[g] = cyc + 1 + int'($urandom_range(3));
          cch[g]  = w;
          crd[g]  = !req_write[g][w];
          ptr[g]  = (w + 1) % N;
          mq.push_back('{e: g, ch: w, wr: req_write[g][w],
                         addr: req_addr[g][w*32 +: 32],
                         wdata: req_wdata[g][w*32 +: 32],
                         mbe: req_mbe[g][w*4 +: 4],
                         cyc: cyc + 1});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      logic  act;
      int    idx;
      int    left;
      mexp_t x;
      rexp_t y;
      act = mem_read[g] | mem_write[g];
      if (zchk) begin
        chks++;
        if ({mem_read[g], mem_write[g], mem_mbe[g], mem_addr[g],
             mem_wdata[g], req_resp[g], req_rdata[g], busy[g],
             grant_id[g]} !== '0) begin
          errs++;
          $display("FAIL reset_zero env%0d cyc%0d: rd=%b wr=%b resp=%b busy=%b grant=%0d addr=%h rdata=%h, required all 0",
                   g, cyc, mem_read[g], mem_write[g], req_resp[g],
                   busy[g], grant_id[g], mem_addr[g], req_rdata[g]);
        end
      end else if (mon_en) begin
        if (act && !pact[g]) begin
          idx = -1;
          foreach (mq[i]) if (idx < 0 && mq[i].e == g) idx = i;
          chks++;
          if (idx < 0) begin
            errs++;
            $display("FAIL mem_unexpected env%0d cyc%0d: rd=%b wr=%b addr=%h, required no transaction",
                     g, cyc, mem_read[g], mem_write[g], mem_addr[g]);
          end else begin
            x = mq[idx];
            mq.delete(idx);
            cur[g] = x;
            if (mem_write[g] !== x.wr || mem_read[g] !== !x.wr
                || mem_addr[g] !== x.addr || mem_wdata[g] !== x.wdata
                || mem_mbe[g] !== x.mbe || grant_id[g] !== 2'(x.ch)
                || busy[g] !== 1'b1 || cyc != x.cyc) begin
              errs++;
              $display("FAIL mem_issue env%0d: cyc=%0d ch=%0d wr=%b addr=%h wdata=%h mbe=%h busy=%b, required cyc=%0d ch=%0d wr=%b addr=%h wdata=%h mbe=%h busy=1",
                       g, cyc, grant_id[g], mem_write[g], mem_addr[g],
                       mem_wdata[g], mem_mbe[g], busy[g], x.cyc, x.ch,
                       x.wr, x.addr, x.wdata, x.mbe);
            end
          end
        end else if (act) begin
          chks++;
          if ({mem_write[g], mem_read[g], mem_addr[g], mem_wdata[g],
               mem_mbe[g], grant_id[g], busy[g]}
              !== {cur[g].wr, !cur[g].wr, cur[g].addr, cur[g].wdata,
                   cur[g].mbe, 2'(cur[g].ch), 1'b1}) begin
            errs++;
            $display("FAIL mem_hold env%0d cyc%0d: wr=%b addr=%h wdata=%h mbe=%h ch=%0d, required wr=%b addr=%h wdata=%h mbe=%h ch=%0d",
                     g, cyc, mem_write[g], mem_addr[g], mem_wdata[g],
                     mem_mbe[g], grant_id[g], cur[g].wr, cur[g].addr,
                     cur[g].wdata, cur[g].mbe, cur[g].ch);
          end
        end
        if (req_resp[g] !== '0) begin
          idx = -1;
          foreach (rq[i]) if (idx < 0 && rq[i].e == g) idx = i;
          chks++;
          if (idx < 0) begin
            errs++;
            $display("FAIL resp_unexpected env%0d cyc%0d: req_resp=%b, required 000",
                     g, cyc, req_resp[g]);
          end else begin
            y = rq[idx];
            rq.delete(idx);
            if (req_resp[g] !== 3'(1 << y.ch) || cyc != y.cyc
                || (y.rd && req_rdata[g] !== y.rdata)
                || busy[g] !== 1'b1 || act !== 1'b0) begin
              errs++;
              $display("FAIL resp env%0d: cyc=%0d resp=%b rdata=%h busy=%b memop=%b, required cyc=%0d resp=%b rdata=%h busy=1 memop=0",
                       g, cyc, req_resp[g], req_rdata[g], busy[g], act,
                       y.cyc, 3'(1 << y.ch), y.rdata);
            end
          end
          bchk[g] = cyc + 1;
        end
        if (cyc == bchk[g]) begin
          chks++;
          if (busy[g] !== 1'b0 || req_resp[g] !== '0) begin
            errs++;
            $display("FAIL idle_after env%0d cyc%0d: busy=%b resp=%b, required busy=0 resp=000",
                     g, cyc, busy[g], req_resp[g]);
          end
        end
      end
      pact[g] = act;
      if (fin) begin
        left = 0;
        foreach (mq[i]) if (mq[i].e == g) left++;
        foreach (rq[i]) if (rq[i].e == g) left++;
        chks++;
        if (left != 0) begin
          errs++;
          $display("FAIL drained env%0d: %0d expected events never seen, required 0",
                   g, left);
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    zchk   = 1'b0;
    mon_en = 1'b0;
    fin    = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req_read[g]  = '0;
      req_write[g] = '0;
      req_mbe[g]   = '0;
      req_addr[g]  = '0;
      req_wdata[g] = '0;
      mem_resp[g]  = 1'b0;
      mem_rdata[g] = '0;
      infl[g]      = 1'b0;
      free_at[g]   = 0;
      ptr[g]       = 0;
      pact[g]      = 1'b0;
      bchk[g]      = -1;
      for (int ch = 0; ch < N; ch++) begin
        served[g][ch] = 1'b0;
        rel[g][ch]    = -1;
      end
    end
    repeat (2) @(posedge clk);
    #1 zchk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    zchk   = 1'b0;
    rst    = 1'b0;
    mon_en = 1'b1;

    repeat (1500) begin @(posedge clk); #1 drive(1); end
    repeat (40)   begin @(posedge clk); #1 drive(0); end
    repeat (40)   begin @(posedge clk); #1 drive(2); end
    repeat (40)   begin @(posedge clk); #1 drive(0); end

    // Read+write on ch0, then reset while the write is in flight.
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      req_read[g][0]     = 1'b1;
      req_write[g][0]    = 1'b1;
      req_addr[g][31:0]  = 32'h0000_1000;
      req_wdata[g][31:0] = 32'hA5A5_5A5A;
      req_mbe[g][3:0]    = 4'hF;
    end
    drive(0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) mem_resp[g] = 1'b0;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    zchk = 1'b1;
    for (int g = 0; g < 2; g++) begin
      mem_resp[g]  = 1'b1;
      mem_rdata[g] = $urandom;
      req_read[g]  = '0;
      req_write[g] = '0;
      infl[g]      = 1'b0;
      ptr[g]       = 0;
      free_at[g]   = cyc + 1;
      for (int ch = 0; ch < N; ch++) begin
        served[g][ch] = 1'b0;
        rel[g][ch]    = -1;
      end
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) mem_resp[g] = 1'b0;
    @(posedge clk);
    #1;
    zchk = 1'b0;
    drive(2);
    repeat (39) begin @(posedge clk); #1 drive(2); end
    repeat (40) begin @(posedge clk); #1 drive(0); end

    @(posedge clk);
    #1 fin = 1'b1;
    @(posedge clk);
    #1 fin = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
